sram2_block_packer: RTL and testbench

//  Downstream consumer of the SRAM2 read path. Issues byte reads to SRAM2 from a start address and

---
 rtl/sram2_pkg.sv | 20 ++
 rtl/rd_valid_pipe.sv | 29 ++
 rtl/sram2_block_packer.sv | 182 ++++++++++++++++++
 tb/tb_sram2_block_packer.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram2_pkg.sv
// sram2_pkg
//   Shared types for the SRAM2 block packer.
//   AES_BLK_BYTES : bytes per AES state block
//   state_t       : packer FSM state encoding
//   aes_blk_t     : one packed 128-bit AES block
package sram2_pkg;

    localparam int AES_BLK_BYTES = 16;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        DRAIN,
        HOLD,
        DONE
    } state_t;

    typedef logic [8*AES_BLK_BYTES-1:0] aes_blk_t;

endpackage

// File: rtl/rd_valid_pipe.sv
// rd_valid_pipe
//   DEPTH-deep shift register of the SRAM2 read strobe. strobe_o is high in
//   the cycle where the data for a read issued DEPTH cycles earlier is on r_data.
//   clk_i    : system clock
//   rst_i    : asynchronous reset, active-high (flushes the pipe)
//   en_i     : read strobe as issued to SRAM2
//   strobe_o : byte-capture strobe
module rd_valid_pipe #(
    parameter int DEPTH = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic strobe_o
);

    logic [DEPTH-1:0] pipe_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= (pipe_q << 1) | DEPTH'(en_i);
        end
    end

    assign strobe_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/sram2_block_packer.sv
// sram2_block_packer
//   Reads bytes from SRAM2 starting at s_addr_i, packs each BLK_BYTES bytes
//   into one block (lowest address in the top byte) and offers it to the AES
//   core over valid/ready. Repeats for n_blk_i blocks (saturated at 16), then
//   pulses done_o.
//   Optional build macro SRAM2_BLK_CNT_EN adds blk_cnt_o, the number of blocks
//   handed over since the last accepted start.
// Ports
//   clk_i, rst_i          : clock, asynchronous active-high reset
//   start_i               : start request, sampled only in IDLE
//   s_addr_i, n_blk_i     : first byte address and block count, latched on start
//   r_en_o, r_addr_o      : SRAM2 read strobe and address
//   r_data_i              : SRAM2 read data, RD_LAT cycles after r_en_o
//   blk_out_o, blk_valid_o, blk_ready_i : block handshake to the AES core
//   busy_o, done_o        : status
//
// state | meaning
// IDLE  | waiting for start
// READ  | issuing BLK_BYTES consecutive byte reads
// DRAIN | waiting for the last in-flight bytes to arrive
// HOLD  | block presented, waiting for blk_ready_i
// DONE  | one-cycle done pulse
module sram2_block_packer
    import sram2_pkg::*;
#(
    parameter int ADDR_BITS = 8,
    parameter int BLK_BYTES = AES_BLK_BYTES,
    parameter int RD_LAT    = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [ADDR_BITS-1:0]   s_addr_i,
    input  logic [4:0]             n_blk_i,
    output logic                   r_en_o,
    output logic [ADDR_BITS-1:0]   r_addr_o,
    input  logic [7:0]             r_data_i,
    output logic [8*BLK_BYTES-1:0] blk_out_o,
    output logic                   blk_valid_o,
    input  logic                   blk_ready_i,
    output logic                   busy_o,
`ifdef SRAM2_BLK_CNT_EN
    output logic [4:0]             blk_cnt_o,
`endif
    output logic                   done_o
);

    localparam int BLK_W = 8*BLK_BYTES;
    localparam int CNT_W = $clog2(BLK_BYTES);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLK_BYTES-1);

    state_t                 state_q;
    logic                   r_en_q;
    logic [ADDR_BITS-1:0]   r_addr_q;
    logic [CNT_W-1:0]       iss_cnt_q;
    logic [CNT_W-1:0]       cap_cnt_q;
    logic [4:0]             rem_q;
    logic [BLK_W-1:0]       acc_q;
    logic [BLK_W-1:0]       acc_d;
    logic [BLK_W-1:0]       blk_q;
    logic                   blk_valid_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   cap_stb;
    logic [4:0]             n_blk_sat;
`ifdef SRAM2_BLK_CNT_EN
    logic [4:0]             blk_cnt_q;
`endif

    rd_valid_pipe #(
        .DEPTH (RD_LAT)
    ) u_rd_valid_pipe (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .en_i     (r_en_q),
        .strobe_o (cap_stb)
    );

    assign acc_d     = {acc_q[BLK_W-9:0], r_data_i};
    assign n_blk_sat = (n_blk_i > 5'd16) ? 5'd16 : n_blk_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            r_en_q      <= 1'b0;
            r_addr_q    <= '0;
            iss_cnt_q   <= '0;
            cap_cnt_q   <= '0;
            rem_q       <= '0;
            acc_q       <= '0;
            blk_q       <= '0;
            blk_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef SRAM2_BLK_CNT_EN
            blk_cnt_q   <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            // Bytes may still be landing in READ (RD_LAT overlap) as well as DRAIN.
            if (cap_stb) begin
                acc_q     <= acc_d;
                cap_cnt_q <= cap_cnt_q + CNT_W'(1);
            end
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        busy_q    <= 1'b1;
                        rem_q     <= n_blk_sat;
                        iss_cnt_q <= '0;
                        cap_cnt_q <= '0;
`ifdef SRAM2_BLK_CNT_EN
                        blk_cnt_q <= '0;
`endif
                        if (n_blk_sat == 5'd0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q  <= READ;
                            r_en_q   <= 1'b1;
                            r_addr_q <= s_addr_i;
                        end
                    end
                end
                READ: begin
                    if (iss_cnt_q == LAST_IDX) begin
                        r_en_q  <= 1'b0;
                        state_q <= DRAIN;
                    end else begin
                        iss_cnt_q <= iss_cnt_q + CNT_W'(1);
                        r_addr_q  <= r_addr_q + ADDR_BITS'(1);
                    end
                end
                DRAIN: begin
                    // The final byte goes straight into blk_q along with the rest.
                    if (cap_stb && (cap_cnt_q == LAST_IDX)) begin
                        blk_q       <= acc_d;
                        blk_valid_q <= 1'b1;
                        cap_cnt_q   <= '0;
                        state_q     <= HOLD;
                    end
                end
                HOLD: begin
                    if (blk_ready_i) begin
                        blk_valid_q <= 1'b0;
                        rem_q       <= rem_q - 5'd1;
`ifdef SRAM2_BLK_CNT_EN
                        blk_cnt_q   <= blk_cnt_q + 5'd1;
`endif
                        if (rem_q != 5'd1) begin
                            state_q   <= READ;
                            r_en_q    <= 1'b1;
                            r_addr_q  <= r_addr_q + ADDR_BITS'(1);
                            iss_cnt_q <= '0;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign r_en_o      = r_en_q;
    assign r_addr_o    = r_addr_q;
    assign blk_out_o   = blk_q;
    assign blk_valid_o = blk_valid_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
`ifdef SRAM2_BLK_CNT_EN
    assign blk_cnt_o   = blk_cnt_q;
`endif

endmodule

// File: tb/tb_sram2_block_packer.sv
module tb_sram2_block_packer;
    import sram2_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        start = 1'b0, start2 = 1'b0;
    logic [7:0]  s_addr = '0, s_addr2 = '0;
    logic [4:0]  n_blk = '0, n_blk2 = '0;
    logic        r_en, r_en2;
    logic [7:0]  r_addr, r_addr2;
    logic [7:0]  r_data, r_data2;
    aes_blk_t    blk_out, blk_out2;
    logic        blk_valid, blk_valid2;
    logic        blk_ready = 1'b0, blk_ready2 = 1'b0;
    logic        busy, busy2, done, done2;
`ifdef SRAM2_BLK_CNT_EN
    logic [4:0]  blk_cnt, blk_cnt2;
`endif

    sram2_block_packer #(.ADDR_BITS(8), .BLK_BYTES(16), .RD_LAT(1)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .s_addr_i(s_addr), .n_blk_i(n_blk),
        .r_en_o(r_en), .r_addr_o(r_addr), .r_data_i(r_data),
        .blk_out_o(blk_out), .blk_valid_o(blk_valid), .blk_ready_i(blk_ready),
        .busy_o(busy),
`ifdef SRAM2_BLK_CNT_EN
        .blk_cnt_o(blk_cnt),
`endif
        .done_o(done)
    );

    sram2_block_packer #(.ADDR_BITS(8), .BLK_BYTES(16), .RD_LAT(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .start_i(start2), .s_addr_i(s_addr2), .n_blk_i(n_blk2),
        .r_en_o(r_en2), .r_addr_o(r_addr2), .r_data_i(r_data2),
        .blk_out_o(blk_out2), .blk_valid_o(blk_valid2), .blk_ready_i(blk_ready2),
        .busy_o(busy2),
`ifdef SRAM2_BLK_CNT_EN
        .blk_cnt_o(blk_cnt2),
`endif
        .done_o(done2)
    );

    // SRAM2 models: byte[a] = a, data appears RD_LAT cycles after r_en.
    logic [7:0] rd1 = '0, rd2a = '0, rd2b = '0;
    always @(posedge clk) begin
        rd1  <= r_en ? r_addr : 8'h00;
        rd2a <= r_en2 ? r_addr2 : 8'h00;
        rd2b <= rd2a;
    end
    assign r_data  = rd1;
    assign r_data2 = rd2b;

    int total = 0;
    int bad = 0;
    int ren_cnt = 0;
    int done_cnt = 0;
    bit valid_seen = 1'b0;
    aes_blk_t exp_q[$];
    aes_blk_t obs_q[$];
    logic [7:0] addr_q[$];

    always @(negedge clk) begin
        if (!rst) begin
            if (r_en) begin
                ren_cnt++;
                addr_q.push_back(r_addr);
            end
            if (done) done_cnt++;
            if (blk_valid) valid_seen = 1'b1;
            if (blk_valid && blk_ready) obs_q.push_back(blk_out);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic aes_blk_t exp_blk(input logic [7:0] a);
        aes_blk_t b;
        for (int i = 0; i < 16; i++) b[127-8*i -: 8] = 8'(a + 8'(i));
        return b;
    endfunction

    task automatic test_reset();
        tick();
        tick();
        total++;
        if ({r_en, r_addr, blk_valid, busy, done} !== 12'h000) begin
            bad++;
            $display("FAIL reset_ctrl: got %0h expected 0", {r_en, r_addr, blk_valid, busy, done});
        end
        total++;
        if (blk_out !== '0) begin
            bad++;
            $display("FAIL reset_blk: got %0h expected 0", blk_out);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        bit ok;
        aes_blk_t e, o;
        s_addr = 8'h10; n_blk = 5'd1; blk_ready = 1'b0;
        exp_q.push_back(exp_blk(8'h10));
        start = 1'b1; tick(); start = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (r_en !== 1'b1 || r_addr !== 8'(8'h10 + 8'(i)) || busy !== 1'b1) ok = 1'b0;
            tick();
        end
        total++;
        if (!ok) begin bad++; $display("FAIL single_read_window: got bad r_en/r_addr/busy expected addrs 10..1f"); end
        total++;
        if (r_en !== 1'b0 || blk_valid !== 1'b0) begin
            bad++; $display("FAIL single_cycle17: got r_en=%0b valid=%0b expected 0 0", r_en, blk_valid);
        end
        tick();
        total++;
        if (blk_valid !== 1'b1 || blk_out !== exp_blk(8'h10)) begin
            bad++; $display("FAIL single_cycle18: got valid=%0b blk=%0h expected 1 %0h", blk_valid, blk_out, exp_blk(8'h10));
        end
        blk_ready = 1'b1; tick();
        total++;
        if (done !== 1'b1 || blk_valid !== 1'b0) begin
            bad++; $display("FAIL single_done: got done=%0b valid=%0b expected 1 0", done, blk_valid);
        end
        blk_ready = 1'b0; tick();
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL single_idle: got done=%0b busy=%0b expected 0 0", done, busy);
        end
`ifdef SRAM2_BLK_CNT_EN
        total++;
        if (blk_cnt !== 5'd1) begin bad++; $display("FAIL single_blk_cnt: got %0d expected 1", blk_cnt); end
`endif
        total++;
        if (obs_q.size() != 1) begin bad++; $display("FAIL single_sb_count: got %0d expected 1", obs_q.size()); end
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            total++;
            if (o !== e) begin bad++; $display("FAIL single_sb: got %0h expected %0h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_back_to_back();
        int ren0, d0, cycles;
        bit ok;
        aes_blk_t e, o;
        s_addr = 8'h10; n_blk = 5'd3; blk_ready = 1'b1;
        ren0 = ren_cnt; d0 = done_cnt; addr_q.delete();
        for (int b = 0; b < 3; b++) exp_q.push_back(exp_blk(8'(8'h10 + 8'(16*b))));
        start = 1'b1; tick(); start = 1'b0;
        cycles = 1;
        while (done !== 1'b1 && cycles < 200) begin tick(); cycles++; end
        total++;
        if (done !== 1'b1 || cycles != 55) begin
            bad++; $display("FAIL b2b_done_cycle: got done=%0b at %0d expected 1 at 55", done, cycles);
        end
        tick(); tick(); tick();
        total++;
        if (ren_cnt - ren0 != 48) begin bad++; $display("FAIL b2b_reads: got %0d expected 48", ren_cnt - ren0); end
        total++;
        if (done_cnt - d0 != 1) begin bad++; $display("FAIL b2b_done_pulses: got %0d expected 1", done_cnt - d0); end
        ok = (addr_q.size() == 48);
        for (int i = 0; i < addr_q.size() && i < 48; i++) if (addr_q[i] !== 8'(8'h10 + 8'(i))) ok = 1'b0;
        total++;
        if (!ok) begin bad++; $display("FAIL b2b_addrs: got %0d addrs expected 48 from 10 to 3f", addr_q.size()); end
        total++;
        if (obs_q.size() != 3) begin bad++; $display("FAIL b2b_sb_count: got %0d expected 3", obs_q.size()); end
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            total++;
            if (o !== e) begin bad++; $display("FAIL b2b_sb: got %0h expected %0h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
        blk_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int ren0, cycles;
        bit ok;
        aes_blk_t held, e, o;
        s_addr = 8'h40; n_blk = 5'd2; blk_ready = 1'b0;
        exp_q.push_back(exp_blk(8'h40)); exp_q.push_back(exp_blk(8'h50));
        start = 1'b1; tick(); start = 1'b0;
        cycles = 0;
        while (blk_valid !== 1'b1 && cycles < 40) begin tick(); cycles++; end
        total++;
        if (blk_valid !== 1'b1) begin bad++; $display("FAIL bp_valid_timeout: got 0 expected 1"); end
        held = blk_out; ren0 = ren_cnt; ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (blk_valid !== 1'b1 || blk_out !== held || r_en !== 1'b0) ok = 1'b0;
        end
        total++;
        if (!ok) begin bad++; $display("FAIL bp_hold_stable: got unstable/no-valid/r_en expected stable hold"); end
        total++;
        if (ren_cnt != ren0) begin bad++; $display("FAIL bp_no_reads: got %0d expected 0", ren_cnt - ren0); end
        blk_ready = 1'b1; tick();
        total++;
        if (blk_valid !== 1'b0 || r_en !== 1'b1 || r_addr !== 8'h50) begin
            bad++; $display("FAIL bp_resume: got valid=%0b r_en=%0b addr=%0h expected 0 1 50", blk_valid, r_en, r_addr);
        end
        cycles = 0;
        while (done !== 1'b1 && cycles < 40) begin tick(); cycles++; end
        total++;
        if (done !== 1'b1) begin bad++; $display("FAIL bp_done_timeout: got 0 expected 1"); end
        tick();
        total++;
        if (obs_q.size() != 2) begin bad++; $display("FAIL bp_sb_count: got %0d expected 2", obs_q.size()); end
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            total++;
            if (o !== e) begin bad++; $display("FAIL bp_sb: got %0h expected %0h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
        blk_ready = 1'b0;
    endtask

    task automatic test_wrap();
        int cycles;
        bit ok;
        aes_blk_t e, o;
        s_addr = 8'hF8; n_blk = 5'd1; blk_ready = 1'b1;
        addr_q.delete();
        exp_q.push_back(128'hF8F9FAFBFCFDFEFF0001020304050607);
        start = 1'b1; tick(); start = 1'b0;
        cycles = 0;
        while (done !== 1'b1 && cycles < 40) begin tick(); cycles++; end
        total++;
        if (done !== 1'b1) begin bad++; $display("FAIL wrap_done_timeout: got 0 expected 1"); end
        tick();
        ok = (addr_q.size() == 16);
        for (int i = 0; i < addr_q.size() && i < 16; i++) if (addr_q[i] !== 8'(8'hF8 + 8'(i))) ok = 1'b0;
        total++;
        if (!ok) begin bad++; $display("FAIL wrap_addrs: got %0d addrs expected f8..ff,00..07", addr_q.size()); end
        total++;
        if (obs_q.size() != 1) begin bad++; $display("FAIL wrap_sb_count: got %0d expected 1", obs_q.size()); end
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            total++;
            if (o !== e) begin bad++; $display("FAIL wrap_sb: got %0h expected %0h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
        blk_ready = 1'b0;
    endtask

    task automatic test_zero_and_busy();
        int ren0, d0, cycles;
        bit seen;
        aes_blk_t e, o;
        s_addr = 8'h33; n_blk = 5'd0; blk_ready = 1'b0;
        ren0 = ren_cnt; d0 = done_cnt;
        start = 1'b1; tick(); start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (done === 1'b1) seen = 1'b1;
            tick();
        end
        total++;
        if (!seen) begin bad++; $display("FAIL zero_done: got 0 expected 1"); end
        total++;
        if (ren_cnt != ren0) begin bad++; $display("FAIL zero_reads: got %0d expected 0", ren_cnt - ren0); end
        total++;
        if (done_cnt - d0 != 1) begin bad++; $display("FAIL zero_done_pulses: got %0d expected 1", done_cnt - d0); end

        s_addr = 8'h60; n_blk = 5'd1;
        ren0 = ren_cnt; d0 = done_cnt;
        exp_q.push_back(exp_blk(8'h60));
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick(); tick(); tick();
        s_addr = 8'h00; n_blk = 5'd5;
        start = 1'b1; tick(); start = 1'b0;
        cycles = 0;
        while (blk_valid !== 1'b1 && cycles < 40) begin tick(); cycles++; end
        start = 1'b1; tick(); start = 1'b0;
        blk_ready = 1'b1;
        cycles = 0;
        while (done !== 1'b1 && cycles < 40) begin tick(); cycles++; end
        blk_ready = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        total++;
        if (ren_cnt - ren0 != 16) begin bad++; $display("FAIL busy_reads: got %0d expected 16", ren_cnt - ren0); end
        total++;
        if (done_cnt - d0 != 1 || busy !== 1'b0) begin
            bad++; $display("FAIL busy_done: got pulses=%0d busy=%0b expected 1 0", done_cnt - d0, busy);
        end
        total++;
        if (obs_q.size() != 1) begin bad++; $display("FAIL busy_sb_count: got %0d expected 1", obs_q.size()); end
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            total++;
            if (o !== e) begin bad++; $display("FAIL busy_sb: got %0h expected %0h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_saturate();
        int ren0, cycles;
        aes_blk_t e, o;
        s_addr = 8'h00; n_blk = 5'd31; blk_ready = 1'b1;
        ren0 = ren_cnt;
        for (int b = 0; b < 16; b++) exp_q.push_back(exp_blk(8'(16*b)));
        start = 1'b1; tick(); start = 1'b0;
        cycles = 1;
        while (done !== 1'b1 && cycles < 400) begin tick(); cycles++; end
        total++;
        if (done !== 1'b1 || cycles != 289) begin
            bad++; $display("FAIL sat_done_cycle: got done=%0b at %0d expected 1 at 289", done, cycles);
        end
        tick();
        total++;
        if (ren_cnt - ren0 != 256) begin bad++; $display("FAIL sat_reads: got %0d expected 256", ren_cnt - ren0); end
`ifdef SRAM2_BLK_CNT_EN
        total++;
        if (blk_cnt !== 5'd16) begin bad++; $display("FAIL sat_blk_cnt: got %0d expected 16", blk_cnt); end
`endif
        total++;
        if (obs_q.size() != 16) begin bad++; $display("FAIL sat_sb_count: got %0d expected 16", obs_q.size()); end
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            total++;
            if (o !== e) begin bad++; $display("FAIL sat_sb: got %0h expected %0h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
        blk_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int cycles;
        aes_blk_t e, o;
        s_addr = 8'h10; n_blk = 5'd1; blk_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        valid_seen = 1'b0;
        rst = 1'b1; #1;
        total++;
        if ({r_en, r_addr, blk_valid, busy, done} !== 12'h000 || blk_out !== '0) begin
            bad++; $display("FAIL rstmid_outputs: got %0h blk=%0h expected 0", {r_en, r_addr, blk_valid, busy, done}, blk_out);
        end
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 30; i++) tick();
        total++;
        if (valid_seen || obs_q.size() != 0 || r_en !== 1'b0) begin
            bad++; $display("FAIL rstmid_quiet: got valid_seen=%0b blocks=%0d expected 0 0", valid_seen, obs_q.size());
        end
        s_addr = 8'h20;
        exp_q.push_back(exp_blk(8'h20));
        start = 1'b1; tick(); start = 1'b0;
        cycles = 0;
        while (done !== 1'b1 && cycles < 40) begin tick(); cycles++; end
        tick();
        total++;
        if (obs_q.size() != 1) begin bad++; $display("FAIL rstmid_sb_count: got %0d expected 1", obs_q.size()); end
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            total++;
            if (o !== e) begin bad++; $display("FAIL rstmid_sb: got %0h expected %0h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
        blk_ready = 1'b0;
    endtask

    task automatic test_rd_lat2();
        int cycles;
        s_addr2 = 8'h10; n_blk2 = 5'd1; blk_ready2 = 1'b0;
        start2 = 1'b1; tick(); start2 = 1'b0;
        cycles = 1;
        while (blk_valid2 !== 1'b1 && cycles < 40) begin tick(); cycles++; end
        total++;
        if (blk_valid2 !== 1'b1 || cycles != 19) begin
            bad++; $display("FAIL lat2_valid_cycle: got valid=%0b at %0d expected 1 at 19", blk_valid2, cycles);
        end
        total++;
        if (blk_out2 !== exp_blk(8'h10)) begin
            bad++; $display("FAIL lat2_blk: got %0h expected %0h", blk_out2, exp_blk(8'h10));
        end
        blk_ready2 = 1'b1; tick(); blk_ready2 = 1'b0;
        total++;
        if (done2 !== 1'b1 || blk_valid2 !== 1'b0) begin
            bad++; $display("FAIL lat2_done: got done=%0b valid=%0b expected 1 0", done2, blk_valid2);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_wrap();
        test_zero_and_busy();
        test_saturate();
        test_reset_mid();
        test_rd_lat2();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
